// File: rtl/button_pkg.sv
// Shared types and helpers for the push-button input conditioner.
package button_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } btn_state_e;

  // Cycles of a clock at freq_hz spanning `amount` time units (units_per_s per second).
  function automatic int cycles_from_time(input int freq_hz, input int amount,
                                          input int units_per_s);
    return (freq_hz / units_per_s) * amount;
  endfunction

endpackage

// File: rtl/button_debouncer_if.sv
// Raw pin plus conditioned level, event pulses and press count of one button.
interface button_debouncer_if;
  logic       btn_in;
  logic       btn_level;
  logic       btn_press;
  logic       btn_release;
  logic       btn_long;
  logic [7:0] press_count;

  modport master (
    output btn_in,
    input  btn_level, btn_press, btn_release, btn_long, press_count
  );

  modport slave (
    input  btn_in,
    output btn_level, btn_press, btn_release, btn_long, press_count
  );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/button_debouncer.sv
// Debounces one mechanical button: synchronise, filter bounce, emit level,
// press/release/long-press pulses and a wrapping press count.
module button_debouncer
  import button_pkg::*;
#(
  parameter int CLK_FREQ      = 80000000,
  parameter int DEBOUNCE_US   = 10000,
  parameter int LONG_PRESS_MS = 1000,
  parameter bit ACTIVE_LOW_IN = 1'b1
) (
  input logic          clk,
  input logic          reset,
  button_debouncer_if.slave bus
);
  localparam int DEBOUNCE_CYCLES = cycles_from_time(CLK_FREQ, DEBOUNCE_US, 1000000);
  localparam int LONG_CYCLES     = cycles_from_time(CLK_FREQ, LONG_PRESS_MS, 1000);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int LW = $clog2(LONG_CYCLES + 1);

  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);
  localparam logic [LW-1:0] LONG_MAX  = LW'(LONG_CYCLES);

  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_params
    $error("button_debouncer: need DEBOUNCE_CYCLES >= 2 and LONG_CYCLES > DEBOUNCE_CYCLES");
  end

  logic s;

  sync_2ff #(.RESET_VAL(1'b0)) u_sync (
    .clk  (clk),
    .rst_n(reset),
    .d    (bus.btn_in ^ ACTIVE_LOW_IN),
    .q    (s)
  );

  btn_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] long_cnt_q, long_cnt_d;
  logic [7:0]    count_q, count_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          long_q, long_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RELEASED;
      cnt_q      <= '0;
      long_cnt_q <= '0;
      count_q    <= '0;
      level_q    <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      long_cnt_q <= long_cnt_d;
      count_q    <= count_d;
      level_q    <= level_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    long_cnt_d = long_cnt_q;
    count_d    = count_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;

    unique case (state_q)
      RELEASED: begin
        if (s) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_d = RELEASED;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = PRESSED;
          press_d    = 1'b1;
          count_d    = count_q + 8'd1;
          long_cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PRESSED: begin
        if (!s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end else begin
          // Saturating at LONG_CYCLES keeps long_cnt off LONG_LAST, so the pulse fires once.
          if (long_cnt_q != LONG_MAX) long_cnt_d = long_cnt_q + LW'(1);
          if (long_cnt_q == LONG_LAST) long_d = 1'b1;
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = RELEASED;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = RELEASED;
    endcase

    level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
  end

  assign bus.btn_level   = level_q;
  assign bus.btn_press   = press_q;
  assign bus.btn_release = release_q;
  assign bus.btn_long    = long_q;
  assign bus.press_count = count_q;
endmodule
